// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder stage: controller state
// encoding and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_cell.sv
// Single-bit full adder cell: the only arithmetic in the serial adder.
// Purely combinational; the carry is stored by the controller.
module bit_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are captured on the accepting edge,
// fed LSB-first through one full-adder cell, and the sum is reassembled in
// an accumulator. The result registers update only on the edge into DONE,
// so the outputs never show a partially built word.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic               cy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;

  logic               cell_s;
  logic               cell_co;
  logic [WIDTH-1:0]   acc_d;

  bit_adder_cell u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (cy_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift/or so it stays legal for WIDTH=1.
  assign acc_d = (acc_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

  // Controller: accept in IDLE, one bit per cycle in SHIFT, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            cy_q    <= c_in;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          cy_q   <= cell_co;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            sum_q   <= acc_d;
            c_out_q <= cell_co;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 1-bit instance checked
// against plain integer addition.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       ci8;
  logic       a1, b1, ci1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic       sum1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] res(input bit w1);
    return w1 ? {7'd0, cout1, sum1} : {cout8, sum8};
  endfunction

  function automatic logic bsy(input bit w1);
    return w1 ? busy1 : busy8;
  endfunction

  function automatic logic dn(input bit w1);
    return w1 ? done1 : done8;
  endfunction

  // One complete operation with latency, busy length, hold and result checks.
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input string tag);
    int         w, cyc, busyc, total;
    bit         got;
    logic [8:0] exp, prev;
    w     = w1 ? 1 : 8;
    total = int'(w1 ? {7'd0, a[0]} : a) + int'(w1 ? {7'd0, b[0]} : b) + int'(ci);
    exp   = 9'(total % (1 << (w + 1)));
    prev  = res(w1);
    if (w1) begin
      start1 = 1'b1; a1 = a[0]; b1 = b[0]; ci1 = ci;
    end else begin
      start8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    end
    step();
    start1 = 1'b0; start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
    busyc = bsy(w1) ? 1 : 0;
    cyc   = 0;
    got   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      chk({tag, " held"}, res(w1), prev);
      step();
      cyc++;
      if (bsy(w1)) busyc++;
      if (dn(w1)) got = 1'b1;
    end
    chk({tag, " done seen"}, got, 1);
    chk({tag, " latency"}, cyc, w);
    chk({tag, " busy cycles"}, busyc, w + 1);
    chk({tag, " result"}, res(w1), exp);
    step();
    chk({tag, " idle busy"}, bsy(w1), 0);
    chk({tag, " done pulse width"}, dn(w1), 0);
    chk({tag, " result kept"}, res(w1), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog busy8=%0b expected=finished", busy8);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pend, held;
    logic [7:0] da, db;
    logic       dc, pb, saw;
    int         last_acc;
    bit         first;

    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset busy8", busy8, 0);
    chk("reset done8", done8, 0);
    chk("reset result8", {cout8, sum8}, 0);
    chk("reset busy1", busy1, 0);
    chk("reset result1", {cout1, sum1}, 0);

    // Reset has priority over start.
    rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    step();
    rst = 1'b0; start8 = 1'b0;
    chk("rst beats start", busy8, 0);

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, "5A+3C");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, "FF+01");
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, "FF+FF+1");

    // start held high with new operands every cycle.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    held = {cout8, sum8};
    last_acc = -1;
    first = 1'b1;
    pend = '0;
    for (int c = 0; c < 30; c++) begin
      pb = busy8; da = a8; db = b8; dc = ci8;
      step();
      if (!pb && busy8) begin
        if (last_acc >= 0) chk("b2b accept period", c - last_acc, 10);
        last_acc = c;
        pend = 9'(da) + 9'(db) + 9'(dc);
      end
      if (done8) begin
        chk("b2b result", {cout8, sum8}, pend);
        if (first) chk("b2b first is 10+20", {cout8, sum8}, 9'h030);
        first = 1'b0;
        held = {cout8, sum8};
      end else if (busy8) begin
        chk("b2b held", {cout8, sum8}, held);
      end
      a8  = (c == 0) ? 8'hAA : 8'($urandom);
      b8  = (c == 0) ? 8'h55 : 8'($urandom);
      ci8 = (c == 0) ? 1'b0  : 1'($urandom);
    end
    start8 = 1'b0;
    chk("b2b three accepted", last_acc, 20);
    chk("b2b ends idle", busy8, 0);

    // Reset in the middle of 7F+01.
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort result", {cout8, sum8}, 0);
    saw = 1'b0;
    repeat (12) begin
      step();
      if (done8) saw = 1'b1;
    end
    chk("abort no done pulse", saw, 0);
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, "7F+01 after abort");

    for (int i = 0; i < 12; i++)
      run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), "random8");

    for (int v = 0; v < 8; v++)
      run_op(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], "w1 truth table");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder stage that drives a single-bit full-adder cell. Operands are presented as parallel words, fed to the cell LSB-first one bit per cycle, and the cell's carry is kept in a flop between cycles. The sum word is reassembled and presented with a completion pulse. This trades WIDTH cycles of latency for one adder cell, for area-constrained datapaths.

Parameters:
WIDTH, 8, operand/sum width in bits (>= 1)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk    in   1      single clock, rising edge
rst    in   1      synchronous, active-high reset
start  in   1      request; accepted only in IDLE
a      in   WIDTH  operand A, sampled on accepting edge
b      in   WIDTH  operand B, sampled on accepting edge
c_in   in   1      carry-in, sampled on accepting edge
busy   out  1      high in SHIFT and DONE
done   out  1      one-cycle completion pulse
sum    out  WIDTH  result, registered
c_out  out  1      final carry, registered

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; busy=0, done=0, sum=0, c_out=0; operand shift regs, carry flop and counter cleared. Reset wins over every other input. Reset mid-operation aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E0 -> load a_sr<=a, b_sr<=b, cy<=c_in, cnt<=0, go SHIFT. start=0 -> stay. sum/c_out hold previous result.
- SHIFT: each edge, the cell computes (s, co) = a_sr[0] + b_sr[0] + cy; acc <= {s, acc[WIDTH-1:1]}; a_sr, b_sr shift right by 1 (zero fill); cy <= co; cnt <= cnt+1. Edges E1..E_WIDTH perform bits 0..WIDTH-1.
- On edge E_WIDTH (cnt==WIDTH-1 before edge): sum <= final acc including bit WIDTH-1, c_out <= co, go DONE.
- DONE: done=1 for exactly that one cycle; edge E_WIDTH+1 -> IDLE.
- Latency: done is high in the cycle after E_WIDTH; start-to-start minimum period WIDTH+2 edges.
- start while busy (SHIFT or DONE) is ignored; no queueing. a/b/c_in may change freely after E0.
- sum/c_out change only on the edge into DONE, stay stable until the next completion or reset; never show partial values.
- Arithmetic: {c_out, sum} == a + b + c_in, modulo 2^(WIDTH+1).
- WIDTH=1: a single SHIFT cycle; same protocol.
- done and busy are registered-state decodes; no combinational path from start to any output.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2) and default WIDTH.
- One sub-module, natural: bit_adder_cell (combinational 1-bit full adder: inputs x, y, ci; outputs s, co), instantiated once. All sequencing, shifting and carry storage live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, start pulse -> done high exactly 9 cycles after start edge, sum=0x96, c_out=0, busy high for 9 cycles.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- Assert start every cycle with new operands during an op (0x10+0x20 in progress, 0xAA+0x55 offered) -> only 0x10+0x20 completes (sum=0x30); the next start is accepted only in the IDLE cycle after done.
- rst asserted at cycle 4 of an op (0x7F+0x01) -> next cycle busy=0, done=0, sum=0, c_out=0; no done pulse follows; a fresh start afterwards completes normally.
- Back-to-back: start held high continuously -> ops accepted every WIDTH+2 edges; sum holds the previous result until each new done.
- WIDTH=1 build: all 8 (a,b,c_in) combinations -> {c_out,sum} matches the full-adder truth table; done 2 cycles after each start.
